// File: rtl/pipeline_cpu_pkg.sv
// Shared definitions for the five-stage pipeline: opcode/funct codes, ALU
// operations, pipeline-register layouts and the NOP encoding.
package pipeline_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_LUI
  } alu_op_e;

  // Decoded instruction travelling from ID into EX
  typedef struct packed {
    alu_op_e     op;
    logic        we;
    logic [4:0]  dst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic        use_imm;
  } id_ex_t;

  // Result carried through EX/MEM and MEM/WB
  typedef struct packed {
    logic        we;
    logic [4:0]  dst;
    logic [31:0] result;
  } ex_wb_t;

  localparam id_ex_t ID_EX_NOP = '0;
  localparam ex_wb_t EX_WB_NOP = '0;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/gp_register_file.sv
// 32x32 general-purpose register file: two asynchronous read ports, one
// synchronous write port, $0 hardwired to zero, write-through on read.
module gp_register_file (
  input  logic        clock,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  // Not reset: contents survive a pipeline reset
  logic [31:0] gp_registers [0:31];

  // Commit the write-back result; $0 is never stored
  always_ff @(posedge clock) begin
    if (we && wa != 5'd0) gp_registers[wa] <= wd;
  end

  // Reads see a same-cycle write so a producer three slots ahead needs no forward
  always_comb begin
    if (ra1 == 5'd0)             rd1 = 32'h0;
    else if (we && wa == ra1)    rd1 = wd;
    else                         rd1 = gp_registers[ra1];
    if (ra2 == 5'd0)             rd2 = 32'h0;
    else if (we && wa == ra2)    rd2 = wd;
    else                         rd2 = gp_registers[ra2];
  end

endmodule

// File: rtl/instruction_memory.sv
// Instruction ROM. Contents are normally preloaded; the load port lets a
// loader fill it in-system and is tied off by the processor top.
module instruction_memory #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic [AW-1:0] addr,
  output logic [31:0]   data,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);

  logic [31:0] ins_memory [0:WORDS-1];

  // Optional in-system load of program words
  always_ff @(posedge clock) begin
    if (load_en) ins_memory[load_addr] <= load_data;
  end

  assign data = ins_memory[addr];

endmodule

// File: rtl/pipeline_cpu.sv
// Five-stage in-order MIPS-subset integer pipeline (IF ID EX MEM WB).
// PIPELINE_FORWARD_EN: defined -> EX-stage forwarding, never stalls;
// undefined -> no forwarding, ID-stage hazard stall with bubble injection.
module pipeline_cpu
  import pipeline_cpu_pkg::*;
#(
  parameter int IM_WORDS = 64
) (
  input logic clock,
  input logic reset
);

  localparam int AW = $clog2(IM_WORDS);

  logic [31:0] pc;
  logic [31:0] fetch_word;
  logic [31:0] if_id;
  id_ex_t      id_ex, dec;
  ex_wb_t      ex_mem, mem_wb, ex_res;
  logic [31:0] rd1, rd2;
  logic [31:0] op_a, fwd_b, op_b;
  logic        stall;

  instruction_memory #(.WORDS(IM_WORDS), .AW(AW)) IM (
    .clock     (clock),
    .addr      (pc[AW+1:2]),
    .data      (fetch_word),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data ('0)
  );

  gp_register_file GPR (
    .clock (clock),
    .ra1   (if_id[25:21]),
    .ra2   (if_id[20:16]),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (mem_wb.we),
    .wa    (mem_wb.dst),
    .wd    (mem_wb.result)
  );

  // Decode the ID instruction; writes to $0 are dropped here so no later stage forwards them
  always_comb begin
    dec         = ID_EX_NOP;
    dec.rs      = if_id[25:21];
    dec.rt      = if_id[20:16];
    dec.rs_val  = rd1;
    dec.rt_val  = rd2;
    case (if_id[31:26])
      OP_RTYPE: begin
        dec.dst = if_id[15:11];
        dec.we  = 1'b1;
        case (if_id[5:0])
          FN_ADD, FN_ADDU: dec.op = ALU_ADD;
          FN_SUB, FN_SUBU: dec.op = ALU_SUB;
          FN_AND:          dec.op = ALU_AND;
          FN_OR:           dec.op = ALU_OR;
          FN_XOR:          dec.op = ALU_XOR;
          FN_NOR:          dec.op = ALU_NOR;
          FN_SLT:          dec.op = ALU_SLT;
          default:         dec.we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        dec.op      = (if_id[31:26] == OP_SLTI) ? ALU_SLT : ALU_ADD;
        dec.we      = 1'b1;
        dec.dst     = if_id[20:16];
        dec.use_imm = 1'b1;
        dec.imm     = sext16(if_id[15:0]);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.op      = (if_id[31:26] == OP_ANDI) ? ALU_AND :
                      (if_id[31:26] == OP_ORI)  ? ALU_OR  : ALU_XOR;
        dec.we      = 1'b1;
        dec.dst     = if_id[20:16];
        dec.use_imm = 1'b1;
        dec.imm     = {16'h0, if_id[15:0]};
      end
      OP_LUI: begin
        dec.op      = ALU_LUI;
        dec.we      = 1'b1;
        dec.dst     = if_id[20:16];
        dec.use_imm = 1'b1;
        dec.imm     = {if_id[15:0], 16'h0};
      end
      default: ;
    endcase
    if (dec.dst == 5'd0) dec.we = 1'b0;
  end

`ifdef PIPELINE_FORWARD_EN
  assign stall = 1'b0;

  // Operand select: EX/MEM wins over MEM/WB, else the value read in ID
  always_comb begin
    if (ex_mem.we && ex_mem.dst != 5'd0 && ex_mem.dst == id_ex.rs)      op_a = ex_mem.result;
    else if (mem_wb.we && mem_wb.dst != 5'd0 && mem_wb.dst == id_ex.rs) op_a = mem_wb.result;
    else                                                                op_a = id_ex.rs_val;
    if (ex_mem.we && ex_mem.dst != 5'd0 && ex_mem.dst == id_ex.rt)      fwd_b = ex_mem.result;
    else if (mem_wb.we && mem_wb.dst != 5'd0 && mem_wb.dst == id_ex.rt) fwd_b = mem_wb.result;
    else                                                                fwd_b = id_ex.rt_val;
  end

  logic unused_bits;
  assign unused_bits = ^{pc[1:0], pc[31:AW+2]};
`else
  logic uses_rs, uses_rt;

  // Hold ID while an older in-flight instruction still owes one of its sources
  always_comb begin
    uses_rs = dec.we && (if_id[31:26] != OP_LUI);
    uses_rt = dec.we && (if_id[31:26] == OP_RTYPE);
    stall   = (uses_rs && ((id_ex.we  && id_ex.dst  != 5'd0 && id_ex.dst  == dec.rs) ||
                           (ex_mem.we && ex_mem.dst != 5'd0 && ex_mem.dst == dec.rs))) ||
              (uses_rt && ((id_ex.we  && id_ex.dst  != 5'd0 && id_ex.dst  == dec.rt) ||
                           (ex_mem.we && ex_mem.dst != 5'd0 && ex_mem.dst == dec.rt)));
  end

  assign op_a  = id_ex.rs_val;
  assign fwd_b = id_ex.rt_val;

  logic unused_bits;
  assign unused_bits = ^{pc[1:0], pc[31:AW+2], id_ex.rs, id_ex.rt};
`endif

  assign op_b = id_ex.use_imm ? id_ex.imm : fwd_b;

  // ALU; arithmetic wraps, slt/slti compare signed
  always_comb begin
    ex_res     = EX_WB_NOP;
    ex_res.we  = id_ex.we;
    ex_res.dst = id_ex.dst;
    case (id_ex.op)
      ALU_ADD: ex_res.result = op_a + op_b;
      ALU_SUB: ex_res.result = op_a - op_b;
      ALU_AND: ex_res.result = op_a & op_b;
      ALU_OR:  ex_res.result = op_a | op_b;
      ALU_XOR: ex_res.result = op_a ^ op_b;
      ALU_NOR: ex_res.result = ~(op_a | op_b);
      ALU_SLT: ex_res.result = {31'h0, $signed(op_a) < $signed(op_b)};
      ALU_LUI: ex_res.result = op_b;
      default: ex_res.result = 32'h0;
    endcase
  end

  // PC and pipeline registers; a stall freezes PC and IF/ID and bubbles ID/EX
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc     <= 32'h0;
      if_id  <= NOP_INSTR;
      id_ex  <= ID_EX_NOP;
      ex_mem <= EX_WB_NOP;
      mem_wb <= EX_WB_NOP;
    end else begin
      if (!stall) begin
        pc    <= pc + 32'd4;
        if_id <= fetch_word;
        id_ex <= dec;
      end else begin
        id_ex <= ID_EX_NOP;
      end
      ex_mem <= ex_res;
      mem_wb <= ex_mem;
    end
  end

endmodule

// File: tb/tb_pipeline_cpu.sv
// Scoreboard bench for pipeline_cpu: each program pushes its expected
// register writes in order; a monitor pops one per write-back it observes.
module tb_pipeline_cpu;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pipeline_cpu #(.IM_WORDS(64)) dut (
    .clock (clock),
    .reset (reset)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] val;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] exp_regs [0:31];
  logic [31:0] prog_q[$];
  int          checks = 0;
  int          passes = 0;
  int          edge_cnt = 0;
  int          last_pop_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clock) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // Monitor: every write-back presented by the DUT must match the next expected write
  always @(negedge clock) begin
    if (dut.mem_wb.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got $%0d=%h expected no write", dut.mem_wb.dst, dut.mem_wb.result);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_dst", {27'h0, dut.mem_wb.dst}, {27'h0, mon_e.dst});
        check("wb_val", dut.mem_wb.result, mon_e.val);
        last_pop_edge = edge_cnt;
      end
    end
  end

  task automatic expect_wr(input int r, input logic [31:0] v);
    wr_t e;
    e.dst = r[4:0];
    e.val = v;
    exp_q.push_back(e);
    exp_regs[r] = v;
  endtask

  // Hold reset, preload IM with prog_q and registers with their index
  task automatic start_test();
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 64; i++) dut.IM.ins_memory[i] = 32'h0;
    for (int i = 0; i < prog_q.size(); i++) dut.IM.ins_memory[i] = prog_q[i];
    for (int i = 0; i < 32; i++) begin
      dut.GPR.gp_registers[i] = i;
      exp_regs[i] = i;
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic check_regs(input string name);
    for (int r = 0; r < 32; r++)
      check($sformatf("%s_r%0d", name, r), dut.GPR.gp_registers[r], exp_regs[r]);
  endtask

  task automatic finish_test(input string name);
    repeat (40) @(negedge clock);
    check({name, "_pending"}, exp_q.size(), 32'd0);
    check_regs(name);
  endtask

  initial begin
    // Reset state
    #3 reset = 1'b1;
    #1;
    check("rst_pc", dut.pc, 32'h0);
    check("rst_if_id", dut.if_id, 32'h0);
    check("rst_id_ex_we", {31'h0, dut.id_ex.we}, 32'h0);
    check("rst_ex_mem_we", {31'h0, dut.ex_mem.we}, 32'h0);
    check("rst_mem_wb_we", {31'h0, dut.mem_wb.we}, 32'h0);

    // Independent ops
    prog_q = '{32'h00a63824, 32'h214b002d};
    start_test();
    expect_wr(7, 32'h4);
    expect_wr(11, 32'h37);
    reset = 1'b0;
    finish_test("indep");

    // Distance-1 forwarding
    prog_q = '{32'h00430820, 32'h00c80825, 32'h00a12023};
    start_test();
    expect_wr(1, 32'h5);
    expect_wr(1, 32'hE);
    expect_wr(4, 32'hFFFFFFF7);
    reset = 1'b0;
    finish_test("dist1");

    // Full chain
    prog_q = '{32'h00a63824, 32'h214b002d, 32'h00430820, 32'h00c80825, 32'h00a12023,
               32'h00293824, 32'h24ea0064, 32'h34ec5555, 32'h01864024, 32'h00000020,
               32'h200d002d, 32'h00c04823, 32'h00c31025};
    start_test();
    expect_wr(7, 32'h4);        expect_wr(11, 32'h37);
    expect_wr(1, 32'h5);        expect_wr(1, 32'hE);
    expect_wr(4, 32'hFFFFFFF7); expect_wr(7, 32'h8);
    expect_wr(10, 32'h6C);      expect_wr(12, 32'h555D);
    expect_wr(8, 32'h4);        expect_wr(13, 32'h2D);
    expect_wr(9, 32'h6);        expect_wr(2, 32'h7);
    reset = 1'b0;
    finish_test("chain");
`ifdef PIPELINE_FORWARD_EN
    check("chain_last_wb_edge", last_pop_edge, 32'd16);
`else
    check("chain_last_wb_edge", last_pop_edge, 32'd22);
`endif

    // $0 protection: a write to $0 in flight must never be forwarded
    prog_q = '{32'h20400007, 32'h00032820, 32'h00003025, 32'h00000020, 32'h00004020};
    start_test();
    expect_wr(5, 32'h3);
    expect_wr(6, 32'h0);
    expect_wr(8, 32'h0);
    reset = 1'b0;
    finish_test("zero");

    // Remaining ops, immediate extension and undecoded encodings
    prog_q = '{32'h3C0E1234, 32'h288FFFFF, 32'h008E802A, 32'h00008827, 32'h3A3200FF,
               32'h00719822, 32'hFC1F0001, 32'h0000F000, 32'h2434FFFE, 32'h32358001};
    start_test();
    expect_wr(14, 32'h12340000);
    expect_wr(15, 32'h0);
    expect_wr(16, 32'h1);
    expect_wr(17, 32'hFFFFFFFF);
    expect_wr(18, 32'hFFFFFF00);
    expect_wr(19, 32'h4);
    expect_wr(20, 32'hFFFFFFFF);
    expect_wr(21, 32'h00008001);
    reset = 1'b0;
    finish_test("misc");

    // Async reset mid-stream: only the first four writes commit before edge 8
    prog_q = '{32'h00a63824, 32'h214b002d, 32'h00430820, 32'h00c80825, 32'h00a12023,
               32'h00293824, 32'h24ea0064, 32'h34ec5555, 32'h01864024};
    start_test();
    expect_wr(7, 32'h4);
    expect_wr(11, 32'h37);
    expect_wr(1, 32'h5);
    expect_wr(1, 32'hE);
    reset = 1'b0;
    repeat (8) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_pc", dut.pc, 32'h0);
    check("midrst_mem_wb_we", {31'h0, dut.mem_wb.we}, 32'h0);
    check("midrst_ex_mem_we", {31'h0, dut.ex_mem.we}, 32'h0);
    check("midrst_pending", exp_q.size(), 32'd0);
    repeat (5) @(negedge clock);
    check_regs("midrst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
